prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have the port clk  in  1  system clock; all logic is on the rising edge.
REQ-002 The block SHALL have the port rst  in  1  reset, synchronous, active-high.
REQ-003 The block SHALL have the port in_valid  in  1  host byte valid.
REQ-004 The block SHALL have the port in_data  in  8  host program byte, little-endian within each word.
REQ-005 The block SHALL have the port in_last  in  1  marks the final program byte; sampled with in_valid.
REQ-006 The block SHALL have the port in_ready  out  1  byte accept; a byte transfers when in_valid and in_ready are both high.
REQ-007 The block SHALL have the port imem_we  out  1  single-cycle instruction-memory write strobe.
REQ-008 The block SHALL have the port imem_waddr  out  6  instruction-memory word index (0..63).
REQ-009 The block SHALL have the port imem_wdata  out  32  instruction word.
REQ-010 The block SHALL have the port core_rst  out  1  holds the datapath core in reset while high.
REQ-011 The block SHALL have the port core_done  in  1  the core's end-of-execution flag; the core halts on fetching word 0.
REQ-012 The block SHALL have the port done  out  1  sticky flag: program ran to completion.
REQ-013 The block SHALL have the port err  out  1  sticky flag: overflow or checksum failure.
REQ-014 The block SHALL have the port word_count  out  7  number of data words written, terminator excluded.

Function
REQ-015 The FSM SHALL have the states LOAD, CHK (present only with the macro), TERM, RUN, DONE and ERR.
REQ-016 In LOAD, in_ready SHALL be 1, and each accepted byte SHALL be placed in lane byte_cnt (bits 8*byte_cnt+7:8*byte_cnt), after which byte_cnt increments modulo 4.
REQ-017 When an accepted byte completes a word (byte_cnt==3), imem_we SHALL be 1 for exactly the next cycle, with imem_waddr=word_count and imem_wdata=the assembled word; word_count then increments.
REQ-018 Input SHALL NOT stall during a write: a byte accepted in the same cycle as imem_we starts the next word.
REQ-019 An accepted byte with in_last=1 SHALL close the program: the partial word is zero-padded in its unfilled upper lanes and written on the next cycle, exactly as in REQ-017.
REQ-020 In that same next cycle the state SHALL become CHK (macro defined) or TERM (macro undefined).
REQ-021 In TERM, in_ready SHALL be 0, and the block SHALL issue one write of 32'h00000000 at imem_waddr=word_count, then go to RUN on the next cycle.
REQ-022 core_rst SHALL be 1 in every state except RUN and DONE, and SHALL be 0 from the first RUN cycle onward.
REQ-023 In RUN, in_ready SHALL be 0; when core_done==1 the block SHALL go to DONE and set done=1.
REQ-024 DONE SHALL be held with core_rst=0 until rst, so the core state stays visible on the displays.
REQ-025 Overflow: when a data word would complete while word_count==63, the block SHALL perform no write and SHALL go to ERR with err=1; slot 63 is reserved for the terminator, so the maximum program is 63 words.
REQ-026 ERR SHALL force in_ready=0, core_rst=1 and imem_we=0 until rst.
REQ-027 in_valid while in_ready=0 SHALL be ignored, and in_last without in_valid SHALL have no effect.
REQ-028 Latency: the last byte is accepted at cycle T, its data write occurs at T+1 and the terminator at T+2; without the macro, core_rst falls at T+3.

Reset
REQ-029 While rst=1, the outputs SHALL be in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_rst=1, done=0, err=0 and word_count=0, with byte_cnt=0 and the assembly buffer cleared.
REQ-030 After rst deasserts, the state SHALL be LOAD.
REQ-031 rst asserted mid-load or mid-run SHALL abort the current operation, restart at word 0 and re-assert core_rst; instruction-memory contents are not cleared.

Configuration
REQ-032 When the macro PROG_LOADER_CKSUM_EN is defined, the block SHALL keep an 8-bit XOR of all accepted data bytes (padding excluded).
REQ-033 With the macro defined, CHK SHALL have in_ready=1 and accept exactly one checksum byte; on a match the state becomes TERM, otherwise ERR with err=1; in_last is ignored in CHK.
REQ-034 When the macro PROG_LOADER_CKSUM_EN is undefined, the CHK state and the XOR register SHALL be absent, and LOAD SHALL go directly to TERM.

Verification
REQ-035 The bench SHALL cover: bytes 13,05,A0,00 with in_last on the 4th -> write addr0=00A00513, then addr1=00000000; core_rst falls at T+3; word_count=1.
REQ-036 The bench SHALL cover: bytes 11,22,33 with last on the 3rd -> write addr0=00332211, terminator at addr1.
REQ-037 The bench SHALL cover: the same 4 bytes with random in_valid gaps of 0..5 cycles -> identical writes and ordering.
REQ-038 The bench SHALL cover: 256 bytes without last -> 63 writes to addr0..62; on the 256th byte, no write occurs, err=1 and core_rst stays 1.
REQ-039 The bench SHALL cover: after load, a single-cycle core_done pulse -> done=1 persists, core_rst stays 0, and in_ready stays 0.
REQ-040 The bench SHALL cover, with PROG_LOADER_CKSUM_EN: bytes 13,05,A0,00 (last) then B6 -> RUN; then B7 -> err=1; and a rst at byte 2 -> next write goes to addr0 with the new bytes.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: streams host program bytes into instruction memory as
// little-endian 32-bit words, appends a zero terminator word, then releases
// the datapath core from reset and waits for its end-of-execution flag.
// Optional checksum byte after the program: define PROG_LOADER_CKSUM_EN.
module prog_loader (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        in_ready,
   output logic        imem_we,
   output logic [5:0]  imem_waddr,
   output logic [31:0] imem_wdata,
   output logic        core_rst,
   input  logic        core_done,
   output logic        done,
   output logic        err,
   output logic [6:0]  word_count
);

   typedef enum logic [2:0] {
      LOAD,
`ifdef PROG_LOADER_CKSUM_EN
      CHK,
`endif
      TERM,
      RUN,
      DONE,
      ERR
   } state_t;

   state_t      state;
   logic [1:0]  byte_cnt;
   logic [31:0] word_buf;
   logic [31:0] assembled;
   logic        accept;
`ifdef PROG_LOADER_CKSUM_EN
   logic [7:0]  cksum;
`endif

   // Host bytes are only taken while loading (or waiting for the checksum byte).
`ifdef PROG_LOADER_CKSUM_EN
   assign in_ready = !rst && (state == LOAD || state == CHK);
`else
   assign in_ready = !rst && (state == LOAD);
`endif

   assign accept = in_valid && in_ready;

   // Current word with the incoming byte dropped into its lane; upper lanes stay zero.
   always_comb begin
      assembled = word_buf;
      assembled[{byte_cnt, 3'b000} +: 8] = in_data;
   end

   // Main loader FSM: word assembly, data/terminator writes, core handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= LOAD;
         byte_cnt   <= 2'd0;
         word_buf   <= 32'd0;
         imem_we    <= 1'b0;
         imem_waddr <= 6'd0;
         imem_wdata <= 32'd0;
         core_rst   <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
         word_count <= 7'd0;
`ifdef PROG_LOADER_CKSUM_EN
         cksum      <= 8'd0;
`endif
      end else begin
         imem_we  <= 1'b0;
         core_rst <= !(state == RUN || state == DONE);
         case (state)
            LOAD: begin
               if (accept) begin
`ifdef PROG_LOADER_CKSUM_EN
                  cksum <= cksum ^ in_data;
`endif
                  if (byte_cnt == 2'd3 || in_last) begin
                     if (word_count == 7'd63) begin
                        state <= ERR;
                        err   <= 1'b1;
                     end else begin
                        imem_we    <= 1'b1;
                        imem_waddr <= word_count[5:0];
                        imem_wdata <= assembled;
                        word_count <= word_count + 7'd1;
                        word_buf   <= 32'd0;
                        byte_cnt   <= 2'd0;
                        if (in_last) begin
`ifdef PROG_LOADER_CKSUM_EN
                           state <= CHK;
`else
                           state <= TERM;
`endif
                        end
                     end
                  end else begin
                     word_buf <= assembled;
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
            end
`ifdef PROG_LOADER_CKSUM_EN
            CHK: begin
               if (accept) begin
                  if (in_data == cksum) begin
                     state <= TERM;
                  end else begin
                     state <= ERR;
                     err   <= 1'b1;
                  end
               end
            end
`endif
            TERM: begin
               imem_we    <= 1'b1;
               imem_waddr <= word_count[5:0];
               imem_wdata <= 32'd0;
               state      <= RUN;
            end
            RUN: begin
               if (core_done) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= DONE;
            end
            ERR: begin
               state <= ERR;
            end
            default: begin
               state <= ERR;
               err   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven program loads plus hand-written sequences for
// gaps, overflow, core completion, mid-load reset and (optionally) checksum.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;
   logic        in_ready;
   logic        imem_we;
   logic [5:0]  imem_waddr;
   logic [31:0] imem_wdata;
   logic        core_rst;
   logic        core_done;
   logic        done;
   logic        err;
   logic [6:0]  word_count;

   prog_loader dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .core_rst   (core_rst),
      .core_done  (core_done),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   typedef struct {
      int          n;
      logic [63:0] bytes;
      int          nw;
      logic [31:0] w0;
      logic [31:0] w1;
   } vec_t;

   vec_t        vecs [5];
   int          asserts = 0;
   int          fails   = 0;
   int          ncnt    = 0;
   int          fall_n  = -1;
   int          wr_addr [$];
   logic [31:0] wr_data [$];
   int          wr_n    [$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      ncnt++;
      if (imem_we === 1'b1) begin
         wr_addr.push_back(int'(imem_waddr));
         wr_data.push_back(imem_wdata);
         wr_n.push_back(ncnt);
      end
      if (fall_n < 0 && core_rst === 1'b0) fall_n = ncnt;
   endtask

   task automatic clearLog();
      wr_addr.delete();
      wr_data.delete();
      wr_n.delete();
      fall_n = -1;
   endtask

   task automatic applyStimulus(input logic [7:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic doReset();
      rst       = 1'b1;
      core_done = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      clearLog();
      tick();
   endtask

   function automatic logic [31:0] expWord(input vec_t v, input int j);
      if (j == 0) return v.w0;
      if (j == 1) return v.w1;
      return 32'h0;
   endfunction

   initial begin
      logic [7:0] b;
      logic [7:0] ck;
      int         nlast;
      int         nref;
      int         gap;
      int         seq_bad;

      vecs[0] = '{4, 64'h0000_0000_00A0_0513, 1, 32'h00A00513, 32'h0};
      vecs[1] = '{3, 64'h0000_0000_0033_2211, 1, 32'h00332211, 32'h0};
      vecs[2] = '{1, 64'h0000_0000_0000_00AA, 1, 32'h000000AA, 32'h0};
      vecs[3] = '{6, 64'h0000_0605_0403_0201, 2, 32'h04030201, 32'h00000605};
      vecs[4] = '{8, 64'h1716_1514_1312_1110, 2, 32'h13121110, 32'h17161514};

      // Reset values
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; core_done = 1'b0;
      tick();
      tick();
      checkOutput("rst in_ready",   32'(in_ready),   32'd0);
      checkOutput("rst imem_we",    32'(imem_we),    32'd0);
      checkOutput("rst imem_waddr", 32'(imem_waddr), 32'd0);
      checkOutput("rst imem_wdata", imem_wdata,      32'd0);
      checkOutput("rst core_rst",   32'(core_rst),   32'd1);
      checkOutput("rst done",       32'(done),       32'd0);
      checkOutput("rst err",        32'(err),        32'd0);
      checkOutput("rst word_count", 32'(word_count), 32'd0);
      rst = 1'b0;
      tick();
      checkOutput("load in_ready", 32'(in_ready), 32'd1);

      // Table-driven program loads
      for (int v = 0; v < 5; v++) begin
         doReset();
         ck = 8'h00;
         nlast = 0;
         for (int i = 0; i < vecs[v].n; i++) begin
            b  = vecs[v].bytes[8*i +: 8];
            ck = ck ^ b;
            applyStimulus(b, (i == vecs[v].n - 1));
         end
         nlast = ncnt - 1;
         nref  = nlast;
`ifdef PROG_LOADER_CKSUM_EN
         applyStimulus(ck, 1'b0);
         nref = ncnt - 1;
`endif
         repeat (5) tick();
         checkOutput($sformatf("v%0d write count", v), 32'(wr_addr.size()), 32'(vecs[v].nw + 1));
         for (int j = 0; j < wr_addr.size(); j++) begin
            checkOutput($sformatf("v%0d addr%0d", v, j), 32'(wr_addr[j]), 32'(j));
            checkOutput($sformatf("v%0d data%0d", v, j), wr_data[j], expWord(vecs[v], j));
         end
         if (wr_n.size() == vecs[v].nw + 1) begin
            checkOutput($sformatf("v%0d data latency", v), 32'(wr_n[vecs[v].nw - 1]), 32'(nlast + 1));
            checkOutput($sformatf("v%0d term latency", v), 32'(wr_n[vecs[v].nw]), 32'(nref + 2));
         end
         checkOutput($sformatf("v%0d core_rst fall", v), 32'(fall_n), 32'(nref + 3));
         checkOutput($sformatf("v%0d word_count", v), 32'(word_count), 32'(vecs[v].nw));
         checkOutput($sformatf("v%0d in_ready", v), 32'(in_ready), 32'd0);
      end

      // Same program with random valid gaps; in_last toggles during gaps without valid
      doReset();
      for (int i = 0; i < 4; i++) begin
         gap = $urandom_range(0, 5);
         repeat (gap) begin
            in_last = 1'b1;
            tick();
            in_last = 1'b0;
         end
         b = vecs[0].bytes[8*i +: 8];
         applyStimulus(b, (i == 3));
      end
`ifdef PROG_LOADER_CKSUM_EN
      applyStimulus(8'hB6, 1'b0);
`endif
      repeat (5) tick();
      checkOutput("gap write count", 32'(wr_addr.size()), 32'd2);
      if (wr_addr.size() == 2) begin
         checkOutput("gap addr0", 32'(wr_addr[0]), 32'd0);
         checkOutput("gap data0", wr_data[0], 32'h00A00513);
         checkOutput("gap addr1", 32'(wr_addr[1]), 32'd1);
         checkOutput("gap data1", wr_data[1], 32'h0);
      end
      checkOutput("gap word_count", 32'(word_count), 32'd1);

      // Core completion pulse; host bytes in RUN/DONE are ignored
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      applyStimulus(8'h55, 1'b1);
      repeat (5) tick();
      checkOutput("done flag", 32'(done), 32'd1);
      checkOutput("done core_rst", 32'(core_rst), 32'd0);
      checkOutput("done in_ready", 32'(in_ready), 32'd0);
      checkOutput("done err", 32'(err), 32'd0);
      checkOutput("done no write", 32'(wr_addr.size()), 32'd2);
      checkOutput("done word_count", 32'(word_count), 32'd1);

      // Reset from DONE re-asserts core reset
      rst = 1'b1;
      tick();
      tick();
      checkOutput("rerun core_rst", 32'(core_rst), 32'd1);
      checkOutput("rerun done", 32'(done), 32'd0);
      rst = 1'b0;

      // Reset in the middle of a load restarts at word 0
      doReset();
      applyStimulus(8'h13, 1'b0);
      applyStimulus(8'h05, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clearLog();
      tick();
      applyStimulus(8'h11, 1'b0);
      applyStimulus(8'h22, 1'b0);
      applyStimulus(8'h33, 1'b1);
`ifdef PROG_LOADER_CKSUM_EN
      applyStimulus(8'h00, 1'b0);
`endif
      repeat (4) tick();
      checkOutput("midrst write count", 32'(wr_addr.size()), 32'd2);
      if (wr_addr.size() >= 1) begin
         checkOutput("midrst addr0", 32'(wr_addr[0]), 32'd0);
         checkOutput("midrst data0", wr_data[0], 32'h00332211);
      end

      // Overflow: 252 bytes fill slots 0..62, the 256th byte trips the error
      doReset();
      for (int i = 0; i < 252; i++) begin
         b = 8'(i);
         applyStimulus(b, 1'b0);
      end
      tick();
      checkOutput("ovf write count", 32'(wr_addr.size()), 32'd63);
      seq_bad = 0;
      for (int j = 0; j < wr_addr.size(); j++) begin
         if (wr_addr[j] != j) seq_bad++;
      end
      checkOutput("ovf addr order", 32'(seq_bad), 32'd0);
      if (wr_data.size() == 63) checkOutput("ovf data62", wr_data[62], 32'hFBFAF9F8);
      checkOutput("ovf word_count", 32'(word_count), 32'd63);
      checkOutput("ovf err early", 32'(err), 32'd0);
      for (int i = 252; i < 256; i++) begin
         b = 8'(i);
         applyStimulus(b, 1'b0);
      end
      tick();
      tick();
      checkOutput("ovf no write", 32'(wr_addr.size()), 32'd63);
      checkOutput("ovf err", 32'(err), 32'd1);
      checkOutput("ovf core_rst", 32'(core_rst), 32'd1);
      checkOutput("ovf in_ready", 32'(in_ready), 32'd0);
      checkOutput("ovf imem_we", 32'(imem_we), 32'd0);
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      tick();
      checkOutput("ovf done stays 0", 32'(done), 32'd0);

`ifdef PROG_LOADER_CKSUM_EN
      // Wrong checksum byte lands in ERR without a terminator
      doReset();
      applyStimulus(8'h13, 1'b0);
      applyStimulus(8'h05, 1'b0);
      applyStimulus(8'hA0, 1'b0);
      applyStimulus(8'h00, 1'b1);
      applyStimulus(8'hB7, 1'b1);
      repeat (4) tick();
      checkOutput("cksum bad err", 32'(err), 32'd1);
      checkOutput("cksum bad core_rst", 32'(core_rst), 32'd1);
      checkOutput("cksum bad writes", 32'(wr_addr.size()), 32'd1);
      checkOutput("cksum bad in_ready", 32'(in_ready), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
